// File: rtl/pipe_array_mul.sv
// pipe_array_mul: pipelined WIDTH x WIDTH shift-and-add array multiplier with valid/ready flow control.
// Optional ARRAY_MUL_SIGNED_EN adds the tc port (Baugh-Wooley two's-complement mode).
module pipe_array_mul #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned ROWS_PER_STAGE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef ARRAY_MUL_SIGNED_EN
    input  logic               tc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);
    localparam int unsigned R = ROWS_PER_STAGE;
    localparam int unsigned N = (WIDTH - 1 + R - 1) / R;

    logic adv;
    logic tc_in;

    // Modified Baugh-Wooley: complement the terms that carry exactly one operand MSB.
    function automatic logic [WIDTH-1:0] pp_row(input logic [WIDTH-1:0] av, input logic bit_b,
                                                input int unsigned i, input logic sgn);
        logic [WIDTH-1:0] r;
        r = av & {WIDTH{bit_b}};
        if (sgn) begin
            if (i == WIDTH - 1) r[WIDTH-2:0] = ~r[WIDTH-2:0];
            else                r[WIDTH-1]   = ~r[WIDTH-1];
        end
        return r;
    endfunction

`ifdef ARRAY_MUL_SIGNED_EN
    assign tc_in = tc;
`else
    assign tc_in = 1'b0;
`endif

    assign adv      = !(out_valid && !out_ready);
    assign in_ready = adv;

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int unsigned LO = k * R + 1;
        localparam int unsigned HI = ((k + 1) * R < WIDTH - 1) ? (k + 1) * R : WIDTH - 1;

        logic [WIDTH-1:0]  a_s;
        logic [WIDTH-1:LO] b_s;
        logic              tc_s;
        logic              v_s;
        logic [WIDTH:0]    acc_c [LO-1:HI];
        logic [WIDTH-2:0]  lsb_c [LO-1:HI];
        logic [WIDTH:0]    acc_q;
        logic [WIDTH-2:0]  lsb_q;
        logic              v_q;

        if (k == 0) begin : g_src
            assign a_s  = a;
            assign b_s  = b[WIDTH-1:1];
            assign tc_s = tc_in;
            assign v_s  = in_valid;
            // The +2^WIDTH Baugh-Wooley correction rides in the carry bit of row 0.
            assign acc_c[0] = {tc_s, pp_row(a, b[0], 0, tc_s)};
            assign lsb_c[0] = '0;
        end else begin : g_src
            assign a_s  = g_stage[k-1].g_mid.a_q;
            assign b_s  = g_stage[k-1].g_mid.b_q;
`ifdef ARRAY_MUL_SIGNED_EN
            assign tc_s = g_stage[k-1].g_mid.tc_q;
`else
            assign tc_s = 1'b0;
`endif
            assign v_s        = g_stage[k-1].v_q;
            assign acc_c[LO-1] = g_stage[k-1].acc_q;
            assign lsb_c[LO-1] = g_stage[k-1].lsb_q;
        end

        for (genvar r = LO; r <= HI; r++) begin : g_row
            assign lsb_c[r] = lsb_c[r-1] | ((WIDTH-1)'(acc_c[r-1][0]) << (r - 1));
            assign acc_c[r] = {1'b0, acc_c[r-1][WIDTH:1]} + {1'b0, pp_row(a_s, b_s[r], r, tc_s)};
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   v_q <= 1'b0;
            else if (adv) v_q <= v_s;
        end

        if (k == N - 1) begin : g_last
            // Output register; the +2^(2*WIDTH-1) correction is a flip of the product MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                    lsb_q <= '0;
                end else if (adv && v_s) begin
                    acc_q <= acc_c[HI] ^ {tc_s, {WIDTH{1'b0}}};
                    lsb_q <= lsb_c[HI];
                end
            end
        end else begin : g_mid
            logic [WIDTH-1:0]    a_q;
            logic [WIDTH-1:HI+1] b_q;
`ifdef ARRAY_MUL_SIGNED_EN
            logic                tc_q;
            always_ff @(posedge clk) begin
                if (adv) tc_q <= tc_s;
            end
`endif
            always_ff @(posedge clk) begin
                if (adv) begin
                    acc_q <= acc_c[HI];
                    lsb_q <= lsb_c[HI];
                    a_q   <= a_s;
                    b_q   <= b_s[WIDTH-1:HI+1];
                end
            end
        end
    end

    assign out_valid = g_stage[N-1].v_q;
    assign p         = {g_stage[N-1].acc_q, g_stage[N-1].lsb_q};

endmodule

// File: tb/tb_pipe_array_mul.sv
// Self-checking bench for pipe_array_mul: directed steps plus a random sweep, scoreboarded
// across three configurations (8x8 R=2, 4x4 R=3, 16x16 R=4).
module tb_pipe_array_mul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready, tc;
    logic [7:0]  a, b;
    logic        in_ready, out_valid;
    logic [15:0] p;
    logic        in_ready4, out_valid4;
    logic [7:0]  p4;
    logic        in_ready16, out_valid16;
    logic [31:0] p16;
    logic [15:0] a16, b16;

    assign a16 = {a, b};
    assign b16 = {b ^ 8'h5A, a};

    int checks = 0;
    int errors = 0;
    logic [63:0] q8[$], q4[$], q16[$];

    pipe_array_mul #(.WIDTH(8), .ROWS_PER_STAGE(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef ARRAY_MUL_SIGNED_EN
        .tc(tc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .p(p));

    pipe_array_mul #(.WIDTH(4), .ROWS_PER_STAGE(3)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4), .a(a[3:0]), .b(b[3:0]),
`ifdef ARRAY_MUL_SIGNED_EN
        .tc(tc),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .p(p4));

    pipe_array_mul #(.WIDTH(16), .ROWS_PER_STAGE(4)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16), .a(a16), .b(b16),
`ifdef ARRAY_MUL_SIGNED_EN
        .tc(tc),
`endif
        .out_valid(out_valid16), .out_ready(out_ready), .p(p16));

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input int w, input logic s);
        logic [63:0] xe, ye, m;
        xe = {32'b0, x};
        ye = {32'b0, y};
        if (s && x[w-1]) xe = xe | (64'hFFFF_FFFF_FFFF_FFFF << w);
        if (s && y[w-1]) ye = ye | (64'hFFFF_FFFF_FFFF_FFFF << w);
        m = (64'd1 << (2 * w)) - 64'd1;
        return (xe * ye) & m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: push on accept, pop and compare on retire, both sampled mid-cycle.
    always @(negedge clk) if (rst_n) begin
        if (in_valid && in_ready)   q8.push_back(model({24'b0, a}, {24'b0, b}, 8, tc));
        if (in_valid && in_ready4)  q4.push_back(model({28'b0, a[3:0]}, {28'b0, b[3:0]}, 4, tc));
        if (in_valid && in_ready16) q16.push_back(model({16'b0, a16}, {16'b0, b16}, 16, tc));
        if (out_valid && out_ready) begin
            if (q8.size() == 0) chk("w8_spurious_out", 64'(out_valid), 64'd0);
            else chk("w8_p", 64'(p), q8.pop_front());
        end
        if (out_valid4 && out_ready) begin
            if (q4.size() == 0) chk("w4_spurious_out", 64'(out_valid4), 64'd0);
            else chk("w4_p", 64'(p4), q4.pop_front());
        end
        if (out_valid16 && out_ready) begin
            if (q16.size() == 0) chk("w16_spurious_out", 64'(out_valid16), 64'd0);
            else chk("w16_p", 64'(p16), q16.pop_front());
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((q8.size() + q4.size() + q16.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(q8.size() + q4.size() + q16.size()), 64'd0);
    endtask

    task automatic stream3(input string tag, input logic [7:0] av [3], input logic [7:0] bv [3],
                           input logic tv [3], input logic [15:0] ev [3]);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; a = av[i]; b = bv[i]; tc = tv[i];
        end
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_gap"}, 64'(out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_p"}, 64'(p), 64'(ev[i]));
        end
        tc = 1'b0;
    endtask

    initial begin
        logic [15:0] first;
        logic        acc;
        int          sent;

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; tc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Single pair: W8/R2 latency 4, W4/R3 latency 1.
        @(posedge clk); #1 a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("lat_w8_valid", 64'(out_valid), 64'(k == 4));
            chk("lat_w4_valid", 64'(out_valid4), 64'(k == 1));
        end
        chk("lat_w8_p", 64'(p), 64'hFE01);

        stream3("b2b", '{8'h03, 8'h10, 8'h00}, '{8'h05, 8'h10, 8'hAB},
                '{1'b0, 1'b0, 1'b0}, '{16'h000F, 16'h0100, 16'h0000});

        // Fill the pipe against a blocked consumer, then hold the stall for 5 cycles.
        @(posedge clk); #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 8'(8'h21 + 8'(i * 7));
            b = 8'(8'hC3 - 8'(i * 5));
            in_valid = 1'b1;
            if (i == 0) first = 16'(model({24'b0, a}, {24'b0, b}, 8, tc));
            if (i < 4) begin @(posedge clk); #1; end
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_p", 64'(p), 64'(first));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        drain("stall_drain");

        // Reset with three products in flight, one of them already at the output.
        @(posedge clk); #1 in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(posedge clk); #1 a = 8'h56; b = 8'h78;
        @(posedge clk); #1 a = 8'h9A; b = 8'hBC;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_p", 64'(p), 64'd0);
        q8.delete(); q4.delete(); q16.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            chk("post_rst_no_stale", 64'(out_valid), 64'd0);
        end

`ifdef ARRAY_MUL_SIGNED_EN
        stream3("signed", '{8'h80, 8'hFF, 8'hFF}, '{8'h80, 8'h02, 8'h02},
                '{1'b1, 1'b1, 1'b0}, '{16'h4000, 16'hFFFE, 16'h01FE});
`endif

        // Random sweep with random source gaps and consumer backpressure.
        sent = 0;
        while (sent < 300) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(0, 4) != 0);
                a = 8'($urandom);
                b = 8'($urandom);
`ifdef ARRAY_MUL_SIGNED_EN
                tc = 1'($urandom_range(0, 1));
`endif
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
